// File: rtl/instruction_fetch_unit.sv
// Fetch-stage producer for IF/ID: single-outstanding imem reads,
// one-entry instruction buffer, stall handling and redirect squash.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] pc,
  output logic [31:0] inst,
  output logic        fvalid
);

  typedef enum logic {ISSUE, WAIT} state_e;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        squash_q, squash_d;
  logic        buf_valid_q, buf_valid_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic fire;
  logic resp;
  logic reload;
  logic unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ISSUE;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      squash_q    <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= RESET_PC;
      buf_inst_q  <= NOP_INST;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      squash_q    <= squash_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign fire   = imem_req && imem_ready;
  assign resp   = (state_q == WAIT) && imem_rvalid;
  assign reload = resp && !squash_q && !redirect;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ISSUE: if (fire) state_d = WAIT;
      WAIT:  if (imem_rvalid) state_d = ISSUE;
      default: state_d = ISSUE;
    endcase
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    squash_d    = squash_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    if (!stall) buf_valid_d = 1'b0;
    if (reload) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = req_pc_q;
      buf_inst_d  = imem_rdata;
    end
    if (resp) squash_d = 1'b0;
    if (fire) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
    // a redirect while waiting must discard the one pending response
    if (redirect) begin
      fetch_pc_d  = {redirect_pc[63:2], 2'b00};
      buf_valid_d = 1'b0;
      if ((state_q == WAIT) && !imem_rvalid) squash_d = 1'b1;
    end
  end

  always_comb begin
    imem_req  = (state_q == ISSUE) && !reset && !redirect
             && (!buf_valid_q || !stall);
    imem_addr = fetch_pc_q;
    pc        = buf_pc_q;
    inst      = buf_valid_q ? buf_inst_q : NOP_INST;
    fvalid    = buf_valid_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random
// traffic against a queue-based model of outstanding fetches.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RST = 64'h1000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        fvalid;

  int errors = 0;
  int checks = 0;
  int lat    = 1;

  instruction_fetch_unit #(.RESET_PC(RST), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .fvalid(fvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  // Memory: one response per accepted request, lat cycles later
  bit          mpend = 0;
  int          mcnt  = 0;
  logic [63:0] maddr = '0;
  always @(posedge clk) begin
    bit nv;
    nv = 1'b0;
    if (reset) begin
      mpend = 1'b0;
    end else begin
      if (imem_rvalid) mpend = 1'b0;
      if (imem_req && imem_ready) begin
        mpend = 1'b1;
        mcnt  = lat - 1;
        maddr = imem_addr;
      end
      if (mpend && mcnt == 0) nv = 1'b1;
      else if (mpend) mcnt--;
    end
    #1;
    imem_rvalid = nv;
    imem_rdata  = nv ? memf(maddr) : 32'hDEAD_BEEF;
  end

  task automatic chk_out(input string n, input logic ev,
                         input logic [63:0] epc, input logic [31:0] ein);
    checks++;
    if (fvalid !== ev || pc !== epc || inst !== ein) begin
      errors++;
      $display("FAIL %s: fvalid=%b pc=%h inst=%h, want %b %h %h",
               n, fvalid, pc, inst, ev, epc, ein);
    end
  endtask

  task automatic chk_req(input string n, input logic er,
                         input logic [63:0] ea);
    checks++;
    if (imem_req !== er || (er && imem_addr !== ea)) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h, want %b %h",
               n, imem_req, imem_addr, er, ea);
    end
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; redirect = 0; redirect_pc = '0;
    imem_ready = 1; lat = 1;
    repeat (2) @(negedge clk);
    #1;
    chk_req("reset_req", 1'b0, '0);
    chk_out("reset_out", 1'b0, RST, NOP);
    reset = 0;
  endtask

  task automatic test_free_run();
    #1 chk_req("run_c0_req", 1'b1, RST);
    chk_out("run_c0_out", 1'b0, RST, NOP);
    @(negedge clk); #1 chk_req("run_c1_req", 1'b0, '0);
    chk_out("run_c1_out", 1'b0, RST, NOP);
    @(negedge clk); #1 chk_out("run_c2_out", 1'b1, RST, memf(RST));
    chk_req("run_c2_req", 1'b1, RST + 4);
    @(negedge clk); #1 chk_req("run_c3_req", 1'b0, '0);
    checks++;
    if (fvalid !== 1'b0 || inst !== NOP) begin
      errors++;
      $display("FAIL run_c3_bubble: fvalid=%b inst=%h, want 0 %h",
               fvalid, inst, NOP);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_req("stall_req", 1'b0, '0);
      chk_out("stall_hold", 1'b1, RST + 4, memf(RST + 4));
      @(negedge clk);
    end
    stall = 0;
    #1 chk_req("stall_drop_req", 1'b1, RST + 8);
    chk_out("stall_drop_out", 1'b1, RST + 4, memf(RST + 4));
    @(negedge clk); #1 chk_req("stall_wait_req", 1'b0, '0);
    @(negedge clk);
  endtask

  task automatic test_redirect_issue();
    #1 chk_out("rdi_pre", 1'b1, RST + 8, memf(RST + 8));
    redirect = 1; redirect_pc = 64'h2002;
    #1 chk_req("rdi_noreq", 1'b0, '0);
    @(negedge clk);
    redirect = 0;
    #1 chk_out("rdi_flush", 1'b0, RST + 8, NOP);
    chk_req("rdi_req", 1'b1, 64'h2000);
  endtask

  task automatic test_redirect_wait();
    lat = 3;
    @(negedge clk);
    redirect = 1; redirect_pc = 64'h3000;
    #1 chk_req("rdw_noreq", 1'b0, '0);
    @(negedge clk);
    redirect = 0;
    #1 chk_req("rdw_c1_req", 1'b0, '0);
    @(negedge clk); #1 chk_out("rdw_rsp_out", 1'b0, RST + 8, NOP);
    chk_req("rdw_rsp_req", 1'b0, '0);
    @(negedge clk); #1 chk_out("rdw_dropped", 1'b0, RST + 8, NOP);
    chk_req("rdw_next_req", 1'b1, 64'h3000);
  endtask

  task automatic test_redirect_rvalid();
    lat = 2;
    @(negedge clk); #1 chk_req("rdr_wait", 1'b0, '0);
    @(negedge clk);
    redirect = 1; redirect_pc = 64'h4000;
    #1 chk_req("rdr_noreq", 1'b0, '0);
    @(negedge clk);
    redirect = 0; lat = 1;
    #1 chk_out("rdr_dropped", 1'b0, RST + 8, NOP);
    chk_req("rdr_req", 1'b1, 64'h4000);
    @(negedge clk);
    @(negedge clk); #1 chk_out("rdr_nosquash", 1'b1, 64'h4000, memf(64'h4000));
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    redirect = 0;
    #1 chk_req("wrap_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    #1 chk_out("wrap_out", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
               memf(64'hFFFF_FFFF_FFFF_FFFC));
    chk_req("wrap_zero", 1'b1, 64'h0);
  endtask

  task automatic test_reset_wait();
    lat = 3;
    @(negedge clk);
    reset = 1;
    #1 chk_req("rstw_req", 1'b0, '0);
    @(negedge clk);
    reset = 0; lat = 1;
    #1 chk_req("rstw_next", 1'b1, RST);
    chk_out("rstw_out", 1'b0, RST, NOP);
    @(negedge clk);
    @(negedge clk); #1 chk_out("rstw_fetch", 1'b1, RST, memf(RST));
  endtask

  typedef struct {
    logic [63:0] pc;
    bit          live;
  } fl_t;

  task automatic test_random();
    fl_t         q[$];
    fl_t         e;
    logic [63:0] m_fetch, m_bpc, tgt;
    bit          m_bv, exp_req, rl;
    bit          s_rst, s_stall, s_redir, s_rv, s_acc;
    @(negedge clk);
    reset = 1; stall = 0; redirect = 0;
    @(negedge clk);
    m_fetch = RST; m_bpc = RST; m_bv = 0;
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom % 80) == 0;
      stall      = ($urandom % 3) == 0;
      redirect   = ($urandom % 12) == 0;
      tgt        = {$urandom, $urandom};
      if ($urandom % 4 == 0) tgt = 64'hFFFF_FFFF_FFFF_FFE0 | tgt[4:0];
      redirect_pc = tgt;
      imem_ready = ($urandom % 4) != 0;
      lat        = $urandom_range(1, 3);
      #1;
      exp_req = q.size() == 0 && !reset && !redirect && (!m_bv || !stall);
      chk_req("rnd_req", exp_req, m_fetch);
      chk_out("rnd_out", m_bv, m_bpc, m_bv ? memf(m_bpc) : NOP);
      s_rst = reset; s_stall = stall; s_redir = redirect;
      s_rv = imem_rvalid; s_acc = exp_req && imem_ready;
      @(posedge clk);
      if (s_rst) begin
        q.delete();
        m_fetch = RST; m_bpc = RST; m_bv = 0;
      end else begin
        rl = 0;
        if (s_rv) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rnd_rvalid: response with 0 outstanding, want 1");
          end else begin
            e = q.pop_front();
            if (e.live && !s_redir) begin
              rl = 1; m_bv = 1; m_bpc = e.pc;
            end
          end
        end
        if (!rl && !s_stall) m_bv = 0;
        if (s_redir) begin
          m_fetch = {tgt[63:2], 2'b00};
          m_bv = 0;
          foreach (q[j]) q[j].live = 0;
        end else if (s_acc) begin
          q.push_back('{m_fetch, 1'b1});
          m_fetch = m_fetch + 64'd4;
        end
      end
      @(negedge clk);
    end
    reset = 0; stall = 0; redirect = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_issue();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage producer for the IF/ID pipeline register of the pipelined RV64 core. Holds the fetch program counter and issues single-outstanding read requests to instruction memory. Buffers one returned instruction and presents it as `pc`/`inst` to IF/ID, which captures on every clock edge where `stall` is 0. Handles decode-stage stalls and branch/jump redirects, including squashing an in-flight response.

## Interface
- `RESET_PC`, 64'h0, fetch address after reset
- `NOP_INST`, 32'h00000013, instruction driven when no valid instruction is buffered (addi x0,x0,0)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  same signal that stalls IF/ID; 1 = IF/ID will not capture this edge
- `redirect`  in  1  branch/jump taken; load new fetch PC, flush
- `redirect_pc`  in  64  redirect target; bits [1:0] ignored (treated as 0)
- `imem_req`  out  1  read request valid
- `imem_addr`  out  64  read address (= fetch_pc)
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  read data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- `imem_rdata`  in  32  instruction word
- `pc`  out  64  PC of presented instruction, to IF/ID
- `inst`  out  32  presented instruction, to IF/ID
- `fvalid`  out  1  1 = `inst` is a real fetched instruction; 0 = bubble (NOP_INST)

## Operation
- State: `fetch_pc`, `req_pc`, FSM {ISSUE, WAIT}, `squash`, one-entry buffer {`buf_valid`, `buf_pc`, `buf_inst`}.
- Outputs: `pc` = `buf_pc`; `inst` = `buf_valid` ? `buf_inst` : NOP_INST; `fvalid` = `buf_valid`; `imem_addr` = `fetch_pc`.
- Consumption: on any edge with `stall`=0 and no reload, `buf_valid` clears (IF/ID took it).
- ISSUE: `imem_req` = !reset && !redirect && (!buf_valid || !stall). On `imem_req && imem_ready`: `req_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4, go WAIT.
- WAIT: `imem_req`=0; buffer is empty by construction. On `imem_rvalid`: if `squash` or `redirect` drop data, else `buf_valid`<=1, `buf_pc`<=`req_pc`, `buf_inst`<=`imem_rdata`; clear `squash`; go ISSUE.
- Redirect (priority over everything except reset): `fetch_pc`<={`redirect_pc`[63:2],2'b00}; `buf_valid`<=0; no request that cycle; if in WAIT without `imem_rvalid`, `squash`<=1 and stay WAIT.
- Redirect while `squash` already set: update `fetch_pc` only; exactly one response still dropped.
- `fetch_pc` arithmetic is 64-bit modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).
- `stall` has no effect in WAIT; a stalled valid buffer holds all outputs unchanged.

## Timing
- Reset (edge with `reset`=1): state ISSUE, `fetch_pc`=`buf_pc`=RESET_PC, `buf_valid`=0, `buf_inst`=NOP_INST, `squash`=0. Outputs: `pc`=RESET_PC, `inst`=NOP_INST, `fvalid`=0, `imem_req`=0 while reset high. Memory shares `reset` and discards outstanding requests; reset mid-WAIT returns to ISSUE with no squash.
- Latency: request accepted edge N, `imem_rvalid` in cycle N+k → `fvalid`=1 from cycle N+k+1.
- Peak throughput with k=1 and `imem_ready`=1: one instruction every 2 cycles.
- Next request issues in the same cycle the buffered instruction is consumed (`stall`=0).
- `imem_req` depends combinationally on `stall`, `redirect`, `reset`; no other input-to-output combinational paths.

## Test plan
- Reset then free-run, RESET_PC=0x1000, ready=1, rvalid 1 cycle later, stall=0 -> requests at 0x1000,0x1004,0x1008; `fvalid` pulses with `pc`=0x1000 then 0x1004, `inst`=NOP_INST between.
- Buffer 0x1004 valid, stall=1 for 3 cycles -> `pc`/`inst` held, `imem_req`=0; request 0x1008 in the cycle stall drops.
- Redirect to 0x2002 in ISSUE with valid buffer -> next cycle `fvalid`=0, `fetch_pc`=0x2000, following request address 0x2000.
- Redirect to 0x3000 in WAIT, response arrives 2 cycles later -> data dropped, `fvalid` stays 0, next request 0x3000.
- Redirect in the same cycle as `imem_rvalid` -> data dropped, next request at redirect target, `squash`=0.
- `fetch_pc`=0xFFFF_FFFF_FFFF_FFFC accepted -> next request address 0; reset asserted during WAIT -> next cycle `imem_req`=1 at RESET_PC, outputs at reset values.
